// File: rtl/neuron_pkg.sv
// Shared types and fixed-point parameters for the serial MAC neuron.
package neuron_pkg;
   localparam int N      = 2;
   localparam int QM     = 12;
   localparam int QN     = 20;
   localparam int W      = QM + QN;
   localparam int SUM_W  = QM + QN + N;
   localparam int NBEATS = 1 << N;

   typedef logic signed [W-1:0]     q_t;
   typedef logic signed [SUM_W-1:0] sum_t;

   typedef enum logic [1:0] {ACC, DRAIN, OUT} mac_state_e;

   localparam q_t Q_ONE = q_t'(64'sd1 <<< QN);
endpackage

// File: rtl/sat_mul.sv
// Signed fixed-point multiply: full product, floor shift by QN, clamp to W bits.
module sat_mul
   import neuron_pkg::*;
(
   input  q_t a,
   input  q_t b,
   output q_t p
);
   localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

   logic signed [2*W-1:0] prod;
   logic signed [2*W-1:0] sh;

   // product widened to 2W, arithmetic shift floors toward -inf, then saturate
   always_comb begin
      prod = a * b;
      sh   = prod >>> QN;
      if (sh > PMAX)
         p = {1'b0, {(W-1){1'b1}}};
      else if (sh < PMIN)
         p = {1'b1, {(W-1){1'b0}}};
      else
         p = sh[W-1:0];
   end
endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron: 2**N beats in, one Q(QM+N.QN) sum out.
module neuron_mac
   import neuron_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  q_t   x_in,
   input  q_t   w_in,
   output logic out_valid,
   input  logic out_ready,
   output sum_t sum_out
);
   mac_state_e   state;
   logic [N-1:0] cnt;
   sum_t         acc;
   q_t           p;
   q_t           p_nxt;
   logic         p_vld;
   logic         p_last;
   logic         beat;

   // ready is decoded from registered state only, so no input-to-output path
   assign in_ready = (state == ACC);
   assign beat     = in_valid && in_ready;

   sat_mul u_mul (
      .a (x_in),
      .b (w_in),
      .p (p_nxt)
   );

   // stage 1: register the saturated product with its valid and last-beat tags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p      <= '0;
         p_vld  <= 1'b0;
         p_last <= 1'b0;
      end else begin
         p      <= beat ? p_nxt : p;
         p_vld  <= beat;
         p_last <= beat && (cnt == N'(NBEATS-1));
      end
   end

   // stage 2 + control: accumulate, hand the final sum to OUT, wait for the consumer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACC;
         cnt       <= '0;
         acc       <= '0;
         sum_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         // the final product only lands in DRAIN; it goes straight to sum_out
         if (p_vld) begin
            if (p_last) begin
               sum_out <= acc + sum_t'(p);
               acc     <= '0;
            end else begin
               acc <= acc + sum_t'(p);
            end
         end
         case (state)
            ACC: begin
               if (beat) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == N'(NBEATS-1)) begin
                     cnt   <= '0;
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (p_vld && p_last)
                  state <= OUT;
            end
            OUT: begin
               // out_valid rises one cycle after entering OUT
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ACC;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state <= ACC;
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac.
module tb_neuron_mac;
   import neuron_pkg::*;

   logic clk;
   logic rst;
   logic in_valid;
   logic in_ready;
   q_t   x_in;
   q_t   w_in;
   logic out_valid;
   logic out_ready;
   sum_t sum_out;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] MASK34 = 64'h3_FFFF_FFFF;

   neuron_mac dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .w_in      (w_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_out   (sum_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // golden model: 64-bit product, floor shift, clamp to 32-bit signed
   function automatic longint gmul(input logic signed [31:0] x, input logic signed [31:0] w);
      longint pr;
      pr = (longint'(x) * longint'(w)) >>> 20;
      if (pr > 64'sd2147483647)  pr = 64'sd2147483647;
      if (pr < -64'sd2147483648) pr = -64'sd2147483648;
      return pr;
   endfunction

   function automatic logic [63:0] gsum(input logic signed [31:0] xs [4], input logic signed [31:0] ws [4]);
      longint s;
      s = 0;
      for (int i = 0; i < 4; i++) s += gmul(xs[i], ws[i]);
      return 64'(s) & MASK34;
   endfunction

   // called at a negedge; returns at the negedge after the accepting edge, in_valid left high
   task automatic beat(input logic signed [31:0] x, input logic signed [31:0] w);
      int k;
      in_valid = 1'b1;
      x_in = x;
      w_in = w;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) chk("beat_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic send4(input logic signed [31:0] xs [4], input logic signed [31:0] ws [4], input bit gaps);
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         beat(xs[i], ws[i]);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int k;
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
   endtask

   task automatic collect(input string tag, input logic [63:0] exp);
      out_ready = 1'b1;
      wait_out(tag);
      chk({tag, "_sum"}, 64'($unsigned(sum_out)), exp);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ovalid_clr"}, 64'(out_valid), 64'd0);
      chk({tag, "_iready_back"}, 64'(in_ready), 64'd1);
   endtask

   logic signed [31:0] xa [4];
   logic signed [31:0] wa [4];
   logic [63:0] e;

   initial begin
      rst = 1'b1; in_valid = 1'b0; x_in = '0; w_in = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_iready", 64'(in_ready), 64'd1);
      chk("rst_ovalid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'($unsigned(sum_out)), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // unity with latency check: out_valid after the second edge past the last beat
      xa = '{Q_ONE, Q_ONE, Q_ONE, Q_ONE}; wa = xa;
      send4(xa, wa, 1'b0);
      chk("lat_iready_t", 64'(in_ready), 64'd0);
      chk("lat_ovalid_t", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_ovalid_t1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_ovalid_t2", 64'(out_valid), 64'd1);
      collect("unity", 64'h0_0040_0000);

      // signed
      xa = '{32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000};
      wa = '{32'h0008_0000, 32'h0008_0000, 32'h0008_0000, 32'h0008_0000};
      send4(xa, wa, 1'b0);
      collect("signed", 64'h3_FFE0_0000);

      // positive and negative saturation
      xa = '{32'h7FF0_0000, 32'h7FF0_0000, 32'h7FF0_0000, 32'h7FF0_0000}; wa = xa;
      send4(xa, wa, 1'b0);
      collect("sat_pos", 64'h1_FFFF_FFFC);
      xa = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      wa = '{32'h7FF0_0000, 32'h7FF0_0000, 32'h7FF0_0000, 32'h7FF0_0000};
      send4(xa, wa, 1'b0);
      collect("sat_neg", 64'h2_0000_0000);

      // floor rounding
      xa = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0};
      wa = '{32'h0008_0000, 32'h0008_0000, 32'h0, 32'h0};
      send4(xa, wa, 1'b0);
      collect("round", 64'h3_FFFF_FFFF);

      // gaps plus 10 cycles of backpressure
      xa = '{32'h0023_4000, 32'hFFC8_0000, 32'h0001_8000, 32'h0100_0000};
      wa = '{32'h0010_0000, 32'h0002_8000, 32'hFF00_0000, 32'hFFFF_0000};
      e = gsum(xa, wa);
      send4(xa, wa, 1'b1);
      wait_out("bp");
      for (int i = 0; i < 10; i++) begin
         chk("bp_sum_hold", 64'($unsigned(sum_out)), e);
         chk("bp_iready_low", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      chk("bp_ovalid_hold", 64'(out_valid), 64'd1);
      collect("bp", e);
      // next neuron must not inherit the previous sum
      xa = '{32'h0004_0000, 32'h0004_0000, 32'hFFF0_0000, 32'h0030_0000};
      wa = '{32'h0020_0000, 32'hFFE0_0000, 32'h0001_0000, 32'h0003_0000};
      e = gsum(xa, wa);
      send4(xa, wa, 1'b1);
      collect("indep", e);

      // reset after two beats
      beat(Q_ONE, Q_ONE);
      beat(Q_ONE, Q_ONE);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_iready", 64'(in_ready), 64'd1);
      chk("rst_mid_ovalid", 64'(out_valid), 64'd0);
      chk("rst_mid_sum", 64'($unsigned(sum_out)), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xa = '{Q_ONE, Q_ONE, Q_ONE, Q_ONE}; wa = xa;
      send4(xa, wa, 1'b0);
      collect("post_rst", 64'h0_0040_0000);

      // reset while a sum is pending in OUT
      send4(xa, wa, 1'b0);
      wait_out("pend");
      rst = 1'b1;
      #1;
      chk("rst_out_ovalid", 64'(out_valid), 64'd0);
      chk("rst_out_sum", 64'($unsigned(sum_out)), 64'd0);
      chk("rst_out_iready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
